// File: rtl/rr_mux_sel.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : rr_mux_sel
// Purpose  : N-channel, W-bit registered mux with direct or round-robin
//            channel selection. Producers use valid/ack per channel; the
//            single consumer sees a valid/ready output register.
// Ports    : clk    - rising-edge clock
//            rst_n  - synchronous active-low reset
//            mode   - 0 = direct select via s, 1 = round-robin
//            s      - direct-mode select (SW bits)
//            d      - packed channel data, channel i = d[i*W +: W]
//            d_vld  - per-channel data valid
//            d_ack  - one-hot capture strobe (combinational)
//            y      - registered output data
//            y_ch   - physical channel index of y
//            y_vld  - y/y_ch valid
//            y_rdy  - consumer accepts y this cycle
// Revision : 1.0 - initial release
// ============================================================================
module rr_mux_sel #(
  parameter int N   = 8,
  parameter int W   = 8,
  parameter int REV = 0,
  localparam int SW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mode,
  input  logic [SW-1:0]   s,
  input  logic [N*W-1:0]  d,
  input  logic [N-1:0]    d_vld,
  output logic [N-1:0]    d_ack,
  output logic [W-1:0]    y,
  output logic [SW-1:0]   y_ch,
  output logic            y_vld,
  input  logic            y_rdy
);

  // Index arithmetic is done one bit wider than SW so that ptr+k (up to
  // 2N-2) and the s<N range check never overflow for non-power-of-2 N.
  localparam logic [SW:0] N_EXT = (SW+1)'(N);
  localparam logic [SW:0] N_M1  = (SW+1)'(N-1);

  logic [SW-1:0] ptr;

  logic          free;
  logic          s_ok;
  logic [SW:0]   c_ext;
  logic          dir_found;
  logic [SW-1:0] dir_idx;
  logic          rr_found;
  logic [SW-1:0] rr_idx;
  logic [SW:0]   scan;
  logic          gnt_vld;
  logic [SW-1:0] gnt_idx;
  logic          load;
  logic [SW-1:0] nxt_ptr;
  logic [W-1:0]  y_nxt;

  always_comb begin
    free    = !y_vld || y_rdy;

    // Direct mode: out-of-range selects simply match no channel, so the
    // grant is a clean 0 rather than an out-of-bounds lookup.
    s_ok      = ({1'b0, s} < N_EXT);
    c_ext     = (REV != 0) ? (N_M1 - {1'b0, s}) : {1'b0, s};
    dir_found = 1'b0;
    dir_idx   = '0;
    for (int i = 0; i < N; i++) begin
      if (s_ok && (c_ext == (SW+1)'(i)) && d_vld[i]) begin
        dir_found = 1'b1;
        dir_idx   = SW'(i);
      end
    end

    // Round-robin: scan ptr, ptr+1, ... wrapping at N; first hit wins.
    rr_found = 1'b0;
    rr_idx   = '0;
    scan     = '0;
    for (int k = 0; k < N; k++) begin
      scan = {1'b0, ptr} + (SW+1)'(k);
      if (scan >= N_EXT) begin
        scan = scan - N_EXT;
      end
      if (!rr_found && d_vld[scan[SW-1:0]]) begin
        rr_found = 1'b1;
        rr_idx   = scan[SW-1:0];
      end
    end

    gnt_vld = mode ? rr_found : dir_found;
    gnt_idx = mode ? rr_idx   : dir_idx;

    load  = rst_n && free && gnt_vld;

    d_ack = '0;
    if (load) begin
      d_ack[gnt_idx] = 1'b1;
    end

    nxt_ptr = (gnt_idx == N_M1[SW-1:0]) ? '0 : gnt_idx + SW'(1);
    y_nxt   = d[int'(gnt_idx)*W +: W];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y     <= '0;
      y_ch  <= '0;
      y_vld <= 1'b0;
      ptr   <= '0;
    end else begin
      if (load) begin
        y     <= y_nxt;
        y_ch  <= gnt_idx;
        y_vld <= 1'b1;
        // Direct-mode grants leave the round-robin position untouched.
        if (mode) begin
          ptr <= nxt_ptr;
        end
      end else if (y_rdy) begin
        y_vld <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rr_mux_sel.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_rr_mux_sel
// Purpose  : Self-checking bench for rr_mux_sel. One instance N=8/REV=1 and
//            one N=5/REV=0 share stimulus; each table row selects which
//            instance is checked. Captured words are queued on d_ack and
//            compared when they appear on y.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_mux_sel;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        mode;
  logic        y_rdy;
  logic [2:0]  s;
  logic [63:0] d;
  logic [7:0]  d_vld;

  logic [7:0]  ack8;
  logic [7:0]  y8;
  logic [2:0]  ych8;
  logic        yv8;
  logic [4:0]  ack5;
  logic [7:0]  y5;
  logic [2:0]  ych5;
  logic        yv5;

  rr_mux_sel #(.N(8), .W(8), .REV(1)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .mode  (mode),
    .s     (s),
    .d     (d),
    .d_vld (d_vld),
    .d_ack (ack8),
    .y     (y8),
    .y_ch  (ych8),
    .y_vld (yv8),
    .y_rdy (y_rdy)
  );

  rr_mux_sel #(.N(5), .W(8), .REV(0)) dut5 (
    .clk   (clk),
    .rst_n (rst_n),
    .mode  (mode),
    .s     (s),
    .d     (d[39:0]),
    .d_vld (d_vld[4:0]),
    .d_ack (ack5),
    .y     (y5),
    .y_ch  (ych5),
    .y_vld (yv5),
    .y_rdy (y_rdy)
  );

  typedef struct {
    bit       u;     // 0 = check N=8 instance, 1 = check N=5 instance
    bit       rst;   // 1 = drive rst_n low this cycle
    bit       mode;
    bit [2:0] s;
    bit [7:0] vld;
    bit       rdy;
    bit [7:0] x;     // xor applied to every channel's data
    bit [7:0] ack;   // expected d_ack this cycle
  } vec_t;

  typedef struct {
    logic [7:0] dat;
    logic [2:0] ch;
  } word_t;

  vec_t  tbl[$];
  word_t sbq[$];
  word_t last;
  logic  ev;
  int    n_cmp;
  int    n_fail;

  task automatic add(input bit u, input bit rst, input bit md, input bit [2:0] sel,
                     input bit [7:0] vld, input bit rdy, input bit [7:0] x,
                     input bit [7:0] ack);
    vec_t v;
    v.u = u; v.rst = rst; v.mode = md; v.s = sel;
    v.vld = vld; v.rdy = rdy; v.x = x; v.ack = ack;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_data(input logic [7:0] x);
    for (int i = 0; i < 8; i++) begin
      d[i*8 +: 8] = (8'hA1 + 8'(i)) ^ x;
    end
  endtask

  function automatic logic [2:0] ack_idx(input logic [7:0] a);
    logic [2:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      if (a[i]) r = 3'(i);
    end
    return r;
  endfunction

  initial begin
    vec_t v;
    logic [7:0] exp_ack;
    word_t w;
    n_cmp  = 0;
    n_fail = 0;

    // ---- N=8, REV=1 -------------------------------------------------------
    add(0,0,0,3'd3,8'hFF,1,8'h00,8'h10); // s=3 -> ch4
    add(0,0,0,3'd0,8'hFF,1,8'h00,8'h80); // s=0 -> ch7
    add(0,0,0,3'd7,8'h01,1,8'h00,8'h01); // s=7 -> ch0
    add(0,0,0,3'd2,8'hDF,1,8'h00,8'h00); // ch5 idle -> no grant
    add(0,0,1,3'd0,8'hA5,1,8'h00,8'h01); // rr 0,2,5,7,0,2
    add(0,0,1,3'd0,8'hA5,1,8'h00,8'h04);
    add(0,0,1,3'd0,8'hA5,1,8'h00,8'h20);
    add(0,0,1,3'd0,8'hA5,1,8'h00,8'h80);
    add(0,0,1,3'd0,8'hA5,1,8'h00,8'h01);
    add(0,0,1,3'd0,8'hA5,1,8'h00,8'h04); // ptr now 3
    add(0,0,0,3'd7,8'hFF,1,8'h00,8'h01); // direct grants leave ptr alone
    add(0,0,0,3'd4,8'hFF,1,8'h00,8'h08);
    add(0,0,1,3'd0,8'hFF,1,8'h00,8'h08); // rr resumes at ch3
    add(0,0,1,3'd0,8'h00,1,8'h00,8'h00); // nothing valid, ptr holds 4
    add(0,0,1,3'd0,8'h01,1,8'h00,8'h01); // scan 4..7 wraps to ch0
    add(0,0,1,3'd0,8'hFF,0,8'h11,8'h00); // backpressure, data changing
    add(0,0,1,3'd0,8'hFF,0,8'h22,8'h00);
    add(0,0,1,3'd0,8'hFF,0,8'h33,8'h00);
    add(0,0,1,3'd0,8'hFF,0,8'h44,8'h00);
    add(0,0,1,3'd0,8'hFF,0,8'h55,8'h00);
    add(0,0,1,3'd0,8'hFF,1,8'h66,8'h02); // release: immediate load
    add(0,0,1,3'd0,8'hFF,1,8'h00,8'h04);
    add(0,1,1,3'd0,8'hFF,1,8'h00,8'h00); // reset with y_vld=1
    add(0,0,1,3'd0,8'hFF,1,8'h00,8'h01); // first grant after reset: ch0
    add(0,0,1,3'd0,8'hFF,1,8'h00,8'h02);
    add(0,1,0,3'd0,8'hFF,1,8'h00,8'h00); // reset before N=5 section
    // ---- N=5, REV=0 -------------------------------------------------------
    add(1,0,0,3'd6,8'h1F,1,8'h00,8'h00); // s>=N -> no grant
    add(1,0,0,3'd2,8'h1F,1,8'h00,8'h04);
    add(1,0,0,3'd6,8'h1F,0,8'h00,8'h00); // word pending, not accepted
    add(1,0,0,3'd6,8'h1F,1,8'h00,8'h00); // accepted, y_vld drops
    add(1,0,0,3'd7,8'h1F,1,8'h00,8'h00);
    add(1,0,0,3'd5,8'h1F,1,8'h00,8'h00);
    add(1,0,0,3'd4,8'h1F,1,8'h00,8'h10); // top channel
    add(1,0,1,3'd0,8'h11,1,8'h00,8'h01); // rr 0,4,0,4 wraps at N
    add(1,0,1,3'd0,8'h11,1,8'h00,8'h10);
    add(1,0,1,3'd0,8'h11,1,8'h00,8'h01);
    add(1,0,1,3'd0,8'h11,1,8'h00,8'h10);
    add(1,0,1,3'd0,8'h1F,1,8'h00,8'h01);
    add(1,0,1,3'd0,8'h1F,1,8'h00,8'h02);
    add(1,0,0,3'd0,8'h00,1,8'h00,8'h00);

    // ---- Reset state (hand sequence) --------------------------------------
    rst_n = 1'b0; mode = 1'b1; s = 3'd0; d_vld = 8'hFF; y_rdy = 1'b1;
    drive_data(8'h00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_y8",     32'(y8),   32'h0);
    chk("rst_ych8",   32'(ych8), 32'h0);
    chk("rst_yvld8",  32'(yv8),  32'h0);
    chk("rst_ack8",   32'(ack8), 32'h0);
    chk("rst_y5",     32'(y5),   32'h0);
    chk("rst_ych5",   32'(ych5), 32'h0);
    chk("rst_yvld5",  32'(yv5),  32'h0);
    chk("rst_ack5",   32'(ack5), 32'h0);
    @(posedge clk); #1;

    last.dat = 8'h00;
    last.ch  = 3'd0;
    ev       = 1'b0;

    // ---- Table ------------------------------------------------------------
    for (int r = 0; r < tbl.size(); r++) begin
      v     = tbl[r];
      rst_n = !v.rst;
      mode  = v.mode;
      s     = v.s;
      d_vld = v.vld;
      y_rdy = v.rdy;
      drive_data(v.x);
      @(negedge clk);
      if (sbq.size() > 0) last = sbq.pop_front();
      exp_ack = v.rst ? 8'h00 : v.ack;
      if (!v.u) begin
        chk($sformatf("r%0d_y", r),    32'(y8),   32'(last.dat));
        chk($sformatf("r%0d_ych", r),  32'(ych8), 32'(last.ch));
        chk($sformatf("r%0d_yvld", r), 32'(yv8),  32'(ev));
        chk($sformatf("r%0d_ack", r),  32'(ack8), 32'(exp_ack));
      end else begin
        chk($sformatf("r%0d_y", r),    32'(y5),   32'(last.dat));
        chk($sformatf("r%0d_ych", r),  32'(ych5), 32'(last.ch));
        chk($sformatf("r%0d_yvld", r), 32'(yv5),  32'(ev));
        chk($sformatf("r%0d_ack", r),  32'({3'b000, ack5}), 32'(exp_ack));
      end
      if (v.rst) begin
        sbq.delete();
        last.dat = 8'h00;
        last.ch  = 3'd0;
        ev       = 1'b0;
      end else if (v.ack != 8'h00) begin
        w.ch  = ack_idx(v.ack);
        w.dat = (8'hA1 + 8'(w.ch)) ^ v.x;
        sbq.push_back(w);
        ev = 1'b1;
      end else if (v.rdy) begin
        ev = 1'b0;
      end
      @(posedge clk); #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
